// File: rtl/mult_pkg.sv
// Shared types and constants for the 16x16 shift-and-add multiplier.
package mult_pkg;

   localparam int unsigned MULT_W    = 16;
   localparam logic [4:0]  ITER_LAST = 5'd15;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/adder_16.sv
// 16-bit adder with carry-in and carry-out; the single adder the multiplier time-shares.
module adder_16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c_i,
   output logic [15:0] s_o,
   output logic        c_o
);

   logic [16:0] sum;

   assign sum = {1'b0, a_i} + {1'b0, b_i} + {16'b0, c_i};
   assign s_o = sum[15:0];
   assign c_o = sum[16];

endmodule

// File: rtl/shift_add_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier, 17 cycles per product.
// Optional overflow flag port enabled by defining MULT_OVF_FLAG_EN.
module shift_add_mult_16
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = MULT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
`ifdef MULT_OVF_FLAG_EN
   ,
   output logic                 ovf
`endif
);

   state_e            state_q, state_d;
   logic [MULT_W-1:0] m_q, m_d;
   logic [MULT_W-1:0] acc_q, acc_d;
   logic [MULT_W-1:0] q_q, q_d;
   logic [4:0]        cnt_q, cnt_d;

   logic [MULT_W-1:0] add_s;
   logic              add_c;
   logic [MULT_W:0]   psum;

   adder_16 u_adder (
      .a_i (acc_q),
      .b_i (m_q),
      .c_i (1'b0),
      .s_o (add_s),
      .c_o (add_c)
   );

   // Partial sum keeps the adder carry as bit 16 so it shifts into acc[15].
   assign psum = q_q[0] ? {add_c, add_s} : {1'b0, acc_q};

`ifdef MULT_OVF_FLAG_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
`ifdef MULT_OVF_FLAG_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef MULT_OVF_FLAG_EN
               ovf_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            {acc_d, q_d} = {psum, q_q[MULT_W-1:1]};
            cnt_d        = cnt_q + 5'd1;
            if (cnt_q == ITER_LAST) begin
               state_d = DONE;
`ifdef MULT_OVF_FLAG_EN
               ovf_d   = |psum[MULT_W:1];
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
`ifdef MULT_OVF_FLAG_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
`ifdef MULT_OVF_FLAG_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = {acc_q, q_q};
`ifdef MULT_OVF_FLAG_EN
   assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_mult_16.sv
// Self-checking bench: vector table plus hand sequences, scoreboard queue of expected products.
module tb_shift_add_mult_16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] prod;
   } vec_t;

   typedef struct {
      logic [31:0] prod;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;
`ifdef MULT_OVF_FLAG_EN
   logic        ovf;
`endif

   int   n_checks;
   int   n_errors;
   exp_t sb[$];
   vec_t vecs[8];

   shift_add_mult_16 #(.WIDTH(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
`ifdef MULT_OVF_FLAG_EN
      ,
      .ovf     (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", nm, act, want);
      end
   endtask

   // Drives a start pulse; returns in the first RUN cycle (sampled #1 after the accepting edge).
   task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev,
                         input bit push, input bit at_neg);
      exp_t e;
      if (at_neg) @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      if (push) begin
         e.prod = ev;
         e.ovf  = |ev[31:16];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
   endtask

   // cyc0 is the cycle index (1 = first RUN cycle) at which this task is entered.
   task automatic wait_done(input string nm, input int cyc0);
      int   cyc;
      int   busy_n;
      bit   seen;
      exp_t e;
      cyc    = cyc0;
      busy_n = 0;
      seen   = 1'b0;
      while (!seen && cyc < 40) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (busy) busy_n++;
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      chk({nm, "_latency"}, 32'(cyc), 32'd17);
      if (cyc0 == 1) chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd16);
      chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_scoreboard: got empty queue required an expected entry", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_product"}, product, e.prod);
`ifdef MULT_OVF_FLAG_EN
         chk({nm, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      end
   endtask

   initial begin
      int          dcount;
      logic [15:0] ra;
      logic [15:0] rb;

      n_checks = 0;
      n_errors = 0;
      vecs[0] = '{16'd3,    16'd5,    32'h0000_000F};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
      vecs[3] = '{16'h1234, 16'h0001, 32'h0000_1234};
      vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
      vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
      vecs[6] = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
      vecs[7] = '{16'h00FF, 16'h00FF, 32'h0000_FE01};

      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_product", product, 32'd0);
`ifdef MULT_OVF_FLAG_EN
      chk("reset_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b1, 1'b1);
         wait_done($sformatf("vec%0d", i), 1);
      end

      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         launch(ra, rb, {16'b0, ra} * {16'b0, rb}, 1'b1, 1'b1);
         wait_done($sformatf("rand%0d", i), 1);
      end

      // Start pulse during RUN must be ignored.
      launch(16'd7, 16'd9, 32'd63, 1'b1, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      start = 1'b1;
      a     = 16'd2;
      b     = 16'd2;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_start", 6);
      @(posedge clk);
      #1;
      chk("busy_start_single_done", 32'(done), 32'd0);
      chk("busy_start_idle_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_product_held", product, 32'd63);

      // Reset during RUN cycle 8 aborts with no done.
      launch(16'hABCD, 16'h1234, 32'd0, 1'b0, 1'b1);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_product", product, 32'd0);
`ifdef MULT_OVF_FLAG_EN
      chk("abort_ovf", 32'(ovf), 32'd0);
`endif
      dcount = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 32'd0);

      // Back-to-back: start held in DONE.
      launch(16'd2, 16'd3, 32'd6, 1'b1, 1'b1);
      wait_done("b2b_first", 1);
      launch(16'h0100, 16'h0100, 32'h0001_0000, 1'b1, 1'b0);
      wait_done("b2b_second", 1);
      @(posedge clk);
      #1;
      chk("b2b_done_pulse", 32'(done), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
